// File: rtl/date_set_controller.sv
// Date-setting front end: steps through date fields on key_mode and issues one-hot increment pulses on key_up.
// Optional auto-repeat on a held key_up is enabled by defining DATE_SET_AUTO_REPEAT_EN.
module date_set_controller #(
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 8,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       key_mode,
    input  logic       key_up,
    output logic       clock_carry,
    output logic [5:0] up,
    output logic [1:0] set,
    output logic [2:0] field,
    output logic       setting
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        S_DAY   = 3'd1,
        S_MONTH = 3'd2,
        S_Y0    = 3'd3,
        S_Y1    = 3'd4,
        S_Y2    = 3'd5,
        S_Y3    = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic          mode_q, up_q;
    logic          mode_edge, up_edge;
    logic [TW-1:0] tcnt;
    logic [5:0]    field_bit;
    logic          rpt_fire;

    assign mode_edge = key_mode && !mode_q;
    assign up_edge   = key_up && !up_q;
    assign field_bit = (state == RUN) ? 6'd0 : (6'd1 << (state - 3'd1));

    // Mode edge outranks both the timeout and any pending key_up edge.
    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            unique case (state)
                RUN:     state_nxt = S_DAY;
                S_DAY:   state_nxt = S_MONTH;
                S_MONTH: state_nxt = S_Y3;
                S_Y3:    state_nxt = S_Y2;
                S_Y2:    state_nxt = S_Y1;
                S_Y1:    state_nxt = S_Y0;
                default: state_nxt = RUN;
            endcase
        end else if (state != RUN && tcnt == TW'(TIMEOUT_TICKS)) begin
            state_nxt = RUN;
        end
    end

`ifdef DATE_SET_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rpt;

    assign rpt_fire = key_up && (rpt == RW'(REPEAT_DELAY));

    // rpt counts cycles since the initial pulse; after firing it reloads so the
    // next fire lands REPEAT_PERIOD cycles later. Zero means idle.
    always_ff @(posedge clock) begin
        if (reset || state_nxt != state || !key_up)
            rpt <= '0;
        else if (up_edge && state != RUN)
            rpt <= RW'(1);
        else if (rpt == RW'(REPEAT_DELAY))
            rpt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else if (rpt != '0)
            rpt <= rpt + RW'(1);
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            mode_q <= 1'b1;
            up_q   <= 1'b1;
            tcnt   <= '0;
            up     <= '0;
        end else begin
            state  <= state_nxt;
            mode_q <= key_mode;
            up_q   <= key_up;
            up     <= (!mode_edge && (up_edge || rpt_fire)) ? field_bit : 6'd0;
            if (state_nxt != state || mode_edge || up_edge)
                tcnt <= '0;
            else if (state != RUN && tick_in && tcnt != TW'(TIMEOUT_TICKS))
                tcnt <= tcnt + TW'(1);
        end
    end

    always_comb begin
        unique case (state)
            RUN:     set = 2'b00;
            S_DAY:   set = 2'b11;
            default: set = 2'b10;
        endcase
    end

    assign field       = state;
    assign setting     = (state != RUN);
    assign clock_carry = tick_in && (state == RUN) && !reset;

endmodule

// File: tb/tb_date_set_controller.sv
// Randomized + directed bench: a per-cycle behavioural model queues expected outputs, a monitor compares them.
module tb_date_set_controller;
    localparam int REPEAT_DELAY  = 24;
    localparam int REPEAT_PERIOD = 8;
    localparam int TIMEOUT_TICKS = 10;

    logic       clock = 0, reset = 1, tick_in = 0, key_mode = 0, key_up = 0;
    logic       clock_carry, setting;
    logic [5:0] up;
    logic [1:0] set;
    logic [2:0] field;

    date_set_controller #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .tick_in(tick_in), .key_mode(key_mode), .key_up(key_up),
        .clock_carry(clock_carry), .up(up), .set(set), .field(field), .setting(setting)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       cc;
        logic [5:0] up;
        logic [1:0] set;
        logic [2:0] field;
        logic       setting;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    int   vectors = 0, miscompares = 0, up0_pulses = 0;

    // Model: field order as a successor table, timeout as a tick count, hold as cycles since press.
    int       NXT[7] = '{1, 2, 6, 0, 3, 4, 5};
    int       ms = 0, mt = 0, mh = 0;
    bit       mpm = 1, mpu = 1, mvalid = 0;
    logic [5:0] mpend = 0;

    task automatic step(input bit rst, input bit tk, input bit km, input bit ku);
        exp_t e;
        int   ns;
        bit   me, ue, fire;
        @(posedge clock);
        #1;
        reset = rst; tick_in = tk; key_mode = km; key_up = ku;
        if (mvalid) begin
            e.cc      = tk && ms == 0 && !rst;
            e.up      = mpend;
            e.set     = (ms == 0) ? 2'b00 : (ms == 1) ? 2'b11 : 2'b10;
            e.field   = 3'(ms);
            e.setting = (ms != 0);
            q.push_back(e);
        end
        if (rst) begin
            ms = 0; mt = 0; mh = 0; mpm = 1; mpu = 1; mpend = 0; mvalid = 1;
        end else begin
            me   = km && !mpm;
            ue   = ku && !mpu;
            fire = 0;
`ifdef DATE_SET_AUTO_REPEAT_EN
            fire = ku && mh >= REPEAT_DELAY && ((mh - REPEAT_DELAY) % REPEAT_PERIOD) == 0;
`endif
            mpend = (ms != 0 && !me && (ue || fire)) ? 6'(1 << (ms - 1)) : 6'd0;
            ns = me ? NXT[ms] : (ms != 0 && mt == TIMEOUT_TICKS) ? 0 : ms;
            if (ns != ms || me || ue) mt = 0;
            else if (ms != 0 && tk && mt < TIMEOUT_TICKS) mt++;
            if (ns != ms || !ku) mh = 0;
            else if (ue && ms != 0) mh = 1;
            else if (mh != 0) mh++;
            ms = ns; mpm = km; mpu = ku;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic press_mode();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (3) @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = '{clock_carry, up, set, field, setting};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got cc=%b up=%b set=%b field=%0d setting=%b, want cc=%b up=%b set=%b field=%0d setting=%b",
                         $time, mon_a.cc, mon_a.up, mon_a.set, mon_a.field, mon_a.setting,
                         mon_e.cc, mon_e.up, mon_e.set, mon_e.field, mon_e.setting);
            end
            if (up[0] === 1'b1) up0_pulses++;
        end
    end

    initial begin
        int base, got, want;
        bit km, ku;
        // Reset, with both keys held through it: release must not create edges.
        step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        idle(2);
        // Ticks pass through in RUN.
        repeat (3) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        // Enter S_DAY, key_up with a tick in the same window.
        press_mode();
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        idle(2);
        // S_MONTH, then simultaneous edges: state steps, no pulse.
        press_mode();
        step(0, 0, 1, 1);
        idle(3);
        // Now S_Y3: one up[5] pulse, then back to RUN through the year digits.
        step(0, 0, 0, 1);
        idle(2);
        repeat (4) press_mode();
        idle(2);
        // Timeout: ten ticks in S_DAY, the timeout-cycle tick is dropped.
        press_mode();
        repeat (TIMEOUT_TICKS) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        idle(2);
        // Held key_up in S_DAY for 48 cycles.
        press_mode();
        drain();
        base = up0_pulses;
        repeat (48) step(0, 0, 0, 1);
        idle(3);
        drain();
        got = up0_pulses - base;
`ifdef DATE_SET_AUTO_REPEAT_EN
        want = 4;
`else
        want = 1;
`endif
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL hold_pulses: got %0d pulses, want %0d", got, want);
        end
        // Random traffic: busy keys, then sparse keys so timeouts occur.
        km = 0; ku = 0;
        for (int i = 0; i < 4000; i++) begin
            int tog = (i < 2000) ? 6 : 40;
            if ($urandom_range(tog - 1) == 0) km = !km;
            if ($urandom_range(tog - 1) == 0) ku = !ku;
            step(($urandom_range(299) == 0), ($urandom_range(2) == 0), km, ku);
        end
        idle(2);
        drain();
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/date_set_controller.md
DATE_SET_CONTROLLER -- requirements
Module: date_set_controller

Interface
REQ-001 Parameter REPEAT_DELAY, default 24, is the number of clock cycles key_up must be held before auto-repeat starts.
REQ-002 Parameter REPEAT_PERIOD, default 8, is the number of clock cycles between auto-repeat pulses.
REQ-003 Parameter TIMEOUT_TICKS, default 10, is the number of tick_in pulses with no key activity after which set mode exits.
REQ-004 Port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port `reset`, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port `tick_in`, input, 1 bit: one-cycle day-advance request from the time counter.
REQ-007 Port `key_mode`, input, 1 bit: level, already synchronized and debounced; 1 = pressed.
REQ-008 Port `key_up`, input, 1 bit: level, already synchronized and debounced; 1 = pressed.
REQ-009 Port `clock_carry`, output, 1 bit: gated day-advance pulse to the date datapath.
REQ-010 Port `up`, output, 6 bits: one-hot, one-cycle increment pulses; [0] day, [1] month, [2] year ones, [3] year tens, [4] year hundreds, [5] year thousands.
REQ-011 Port `set`, output, 2 bits: date datapath mode.
REQ-012 Port `field`, output, 3 bits: the field currently selected, for the display blink logic.
REQ-013 Port `setting`, output, 1 bit: high in every state except RUN.

Function
REQ-014 The FSM states shall be RUN(0), S_DAY(1), S_MONTH(2), S_Y0(3), S_Y1(4), S_Y2(5), S_Y3(6); `field` shall equal the state code.
REQ-015 A rising edge of key_mode (key_mode=1 while its registered value=0) shall step the state RUN->S_DAY->S_MONTH->S_Y3->S_Y2->S_Y1->S_Y0->RUN, one step per edge.
REQ-016 `set` shall be 2'b00 in RUN, 2'b11 in S_DAY, and 2'b10 in all other set states.
REQ-017 `clock_carry` shall equal tick_in in RUN and 0 in every set state; ticks arriving in set states are dropped, not queued.
REQ-018 In a set state, a rising edge of key_up shall produce exactly one one-cycle pulse on the `up` bit of the selected field, registered (1 cycle after the edge).
REQ-019 `up` shall be all-zero in RUN and whenever no pulse is due; at most one bit is high in any cycle.
REQ-020 If key_mode and key_up edges occur in the same cycle, the mode edge wins: the state steps and no `up` pulse is issued.
REQ-021 The timeout counter (width ceil(log2(TIMEOUT_TICKS+1))) shall clear on any key edge or any state change, and shall increment on each tick_in in a set state.
REQ-022 When the timeout counter reaches TIMEOUT_TICKS, the state shall return to RUN on the next cycle; that cycle's tick_in is not passed through.
REQ-023 Setting values, wrap-around and range limits are owned by the datapath; this block only generates pulses.

Reset
REQ-024 While reset=1 at a clock edge: state=RUN, set=00, up=0, clock_carry=0, setting=0, field=0, all counters=0, and the registered key values=1 (so a key held through reset produces no edge).
REQ-025 Reset asserted in any set state shall return to RUN on that edge, with no `up` pulse issued.

Configuration
REQ-026 With macro DATE_SET_AUTO_REPEAT_EN defined: holding key_up continuously for REPEAT_DELAY cycles after the initial pulse shall produce an additional `up` pulse, then one pulse every REPEAT_PERIOD cycles until release; releasing key_up or a state change clears the repeat counter.
REQ-027 With DATE_SET_AUTO_REPEAT_EN undefined, the repeat counter logic shall be absent, and holding key_up shall yield exactly one pulse per press.

Verification
REQ-028 Reset, then tick_in pulsed 3 times in RUN -> clock_carry pulses 3 times, up=0, set=00.
REQ-029 key_mode edge, then key_up edge -> state S_DAY, set=11, up=6'b000001 for exactly 1 cycle; a tick_in in the same window -> clock_carry stays 0.
REQ-030 key_mode edges x3, then key_up edge -> field=6 (S_Y3), up=6'b100000 once; 4 more key_mode edges -> RUN, set=00.
REQ-031 In S_MONTH, key_mode and key_up edges in the same cycle -> state S_Y3, no `up` pulse.
REQ-032 In S_DAY with no key activity, 10 tick_in pulses -> RUN on the following cycle, and the timeout-cycle tick is not passed through.
REQ-033 DATE_SET_AUTO_REPEAT_EN defined, key_up held 48 cycles in S_DAY -> up[0] pulses at cycles 1, 25, 33, 41 (4 pulses); macro undefined -> 1 pulse.
